// File: rtl/banked_memory_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : banked_memory_ctrl
//  Purpose  : Valid/ready word-addressed front end over NUM_BANKS synchronous
//             RAM banks. Byte-enable writes, 2-cycle pipelined reads,
//             out-of-range detection and a hardware zero-clear sweep.
//  Revision : 1.0  initial release
// ============================================================================
module banked_memory_ctrl #(
    parameter int DATA_W    = 16,
    parameter int BANK_AW   = 14,
    parameter int NUM_BANKS = 4,
    parameter int ADDR_W    = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy
);

    localparam int BE_W       = DATA_W / 8;
    localparam int BK_W       = ADDR_W - BANK_AW;
    localparam int BANK_DEPTH = 2 ** BANK_AW;
    localparam logic [BANK_AW-1:0] C_LAST = '1;
    localparam logic [BK_W:0]      C_NB   = (BK_W + 1)'(NUM_BANKS);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [BANK_AW-1:0]   cnt_q, cnt_d;
    logic                 req_ready_q, req_ready_d;
    logic                 busy_q, busy_d;

    // Read pipeline: stage 1 holds the accepted read, stage 2 the RAM access
    logic                 rd1_vld_q, rd1_vld_d;
    logic [BANK_AW-1:0]   rd1_off_q, rd1_off_d;
    logic [BK_W-1:0]      rd1_bank_q, rd1_bank_d;
    logic                 rd1_err_q, rd1_err_d;
    logic                 rd2_vld_q, rd2_vld_d;
    logic [BK_W-1:0]      rd2_bank_q, rd2_bank_d;
    logic                 rd2_err_q, rd2_err_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]    rsp_rdata_q, rsp_rdata_d;
    logic                 rsp_err_q, rsp_err_d;

    logic [DATA_W-1:0]    ram_q [NUM_BANKS];
    logic [DATA_W-1:0]    w_sel;

    logic [BK_W-1:0]      w_bank;
    logic [BANK_AW-1:0]   w_off;
    logic                 w_oob;
    logic                 w_accept;
    logic                 w_sweep;

    assign w_bank   = req_addr[ADDR_W-1:BANK_AW];
    assign w_off    = req_addr[BANK_AW-1:0];
    assign w_oob    = ({1'b0, w_bank} >= C_NB);
    assign w_accept = req_valid & req_ready_q;
    assign w_sweep  = (state_q == ST_CLEAR);

    // One RAM per bank; the sweep writes zero to the same offset in all banks
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [DATA_W-1:0]  mem_q [BANK_DEPTH];
        logic               w_we;
        logic [BANK_AW-1:0] w_waddr;
        logic [DATA_W-1:0]  w_wdata;
        logic [BE_W-1:0]    w_be;

        assign w_we    = w_sweep | (w_accept & req_write & ~w_oob & (w_bank == BK_W'(b)));
        assign w_waddr = w_sweep ? cnt_q : w_off;
        assign w_wdata = w_sweep ? '0 : req_wdata;
        assign w_be    = w_sweep ? '1 : req_be;

        // Byte-lane write port and registered read port
        always_ff @(posedge clk) begin
            if (w_we) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (w_be[i]) begin
                        mem_q[w_waddr][i*8 +: 8] <= w_wdata[i*8 +: 8];
                    end
                end
            end
            if (rd1_vld_q) begin
                ram_q[b] <= mem_q[rd1_off_q];
            end
        end
    end

    // Pick the read data of the bank that travelled down with the request
    always_comb begin
        w_sel = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (rd2_bank_q == BK_W'(b)) begin
                w_sel = ram_q[b];
            end
        end
    end

    // Next-state for sweep control, read pipeline and response registers
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (clear) begin
            state_d = ST_CLEAR;
            cnt_d   = '0;
        end else if (state_q == ST_CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == C_LAST) begin
                state_d = ST_IDLE;
            end
        end
        req_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d == ST_CLEAR);

        rd1_vld_d  = w_accept & ~req_write;
        rd1_off_d  = w_off;
        rd1_bank_d = w_bank;
        rd1_err_d  = w_oob;
        rd2_vld_d  = rd1_vld_q;
        rd2_bank_d = rd1_bank_q;
        rd2_err_d  = rd1_err_q;

        rsp_valid_d = rd2_vld_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        if (rd2_vld_q) begin
            rsp_err_d   = rd2_err_q;
            rsp_rdata_d = rd2_err_q ? '0 : w_sel;
        end
    end

    // Control and pipeline registers; reset flushes in-flight reads
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_CLEAR;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            rd1_vld_q   <= 1'b0;
            rd1_off_q   <= '0;
            rd1_bank_q  <= '0;
            rd1_err_q   <= 1'b0;
            rd2_vld_q   <= 1'b0;
            rd2_bank_q  <= '0;
            rd2_err_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            rd1_vld_q   <= rd1_vld_d;
            rd1_off_q   <= rd1_off_d;
            rd1_bank_q  <= rd1_bank_d;
            rd1_err_q   <= rd1_err_d;
            rd2_vld_q   <= rd2_vld_d;
            rd2_bank_q  <= rd2_bank_d;
            rd2_err_q   <= rd2_err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = req_ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_banked_memory_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_banked_memory_ctrl
//  Purpose  : Scoreboard bench for banked_memory_ctrl. Small banks (16 words)
//             and 3 of 4 possible banks so the sweep is short and the top
//             bank index is out of range.
//  Revision : 1.0  initial release
// ============================================================================
module tb_banked_memory_ctrl;

    localparam int DATA_W    = 16;
    localparam int BANK_AW   = 4;
    localparam int NUM_BANKS = 3;
    localparam int ADDR_W    = 6;
    localparam int DEPTH     = 2 ** BANK_AW;
    localparam int SPACE     = 2 ** ADDR_W;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 clear;
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic [ADDR_W-1:0]    req_addr;
    logic [DATA_W-1:0]    req_wdata;
    logic [DATA_W/8-1:0]  req_be;
    logic                 rsp_valid;
    logic [DATA_W-1:0]    rsp_rdata;
    logic                 rsp_err;
    logic                 busy;

    banked_memory_ctrl #(
        .DATA_W    (DATA_W),
        .BANK_AW   (BANK_AW),
        .NUM_BANKS (NUM_BANKS),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic              e;
        int                c;
    } exp_t;

    exp_t              sb_q[$];
    logic [DATA_W-1:0] model [SPACE];
    int                cyc = 0;
    int                n_cmp = 0;
    int                n_bad = 0;
    logic [DATA_W-1:0] last_rdata = '0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    function automatic bit is_oob(input int a);
        return (a / DEPTH) >= NUM_BANKS;
    endfunction

    // Reference model: flat word array updated for every accepted request
    always @(posedge clk) begin
        cyc++;
        if (!reset_n) begin
            sb_q.delete();
            for (int a = 0; a < SPACE; a++) model[a] = '0;
        end else begin
            if (req_valid && req_ready) begin
                if (req_write) begin
                    if (!is_oob(int'(req_addr))) begin
                        for (int i = 0; i < DATA_W / 8; i++)
                            if (req_be[i]) model[req_addr][i*8 +: 8] = req_wdata[i*8 +: 8];
                    end
                end else begin
                    exp_t e;
                    e.e = is_oob(int'(req_addr));
                    e.d = e.e ? '0 : model[req_addr];
                    e.c = cyc + 2;
                    sb_q.push_back(e);
                end
            end
            if (clear) begin
                for (int a = 0; a < SPACE; a++) model[a] = '0;
            end
        end
    end

    // Monitor: compares every response and checks data hold between responses
    always begin
        @(posedge clk);
        #1;
        if (!reset_n) begin
            last_rdata = '0;
        end else if (rsp_valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_rsp", 32'(rsp_valid), 32'(0));
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("rsp_rdata", 32'(rsp_rdata), 32'(e.d));
                check("rsp_err", 32'(rsp_err), 32'(e.e));
                check("rsp_cycle", 32'(cyc), 32'(e.c));
            end
            last_rdata = rsp_rdata;
        end else begin
            check("rdata_hold", 32'(rsp_rdata), 32'(last_rdata));
        end
    end

    task automatic check_reset_outs();
        check("rst_req_ready", 32'(req_ready), 32'(0));
        check("rst_busy", 32'(busy), 32'(1));
        check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'(0));
        check("rst_rsp_err", 32'(rsp_err), 32'(0));
    endtask

    // Counts edges until busy drops; starts just before the first sweep edge
    task automatic sweep_check(input string nm);
        int n = 0;
        while (busy && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(nm, 32'(n), 32'(DEPTH));
        check("ready_after_sweep", 32'(req_ready), 32'(1));
    endtask

    task automatic issue(input logic w, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic [1:0] be);
        int n = 0;
        @(negedge clk);
        clear = 1'b0;
        while (!req_ready && n < 100) begin
            req_valid = 1'b0;
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_cmp++;
            n_bad++;
            $display("FAIL issue_wait: req_ready got 0, required 1");
        end
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid = 1'b0;
        clear     = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        req_valid = 1'b0;
        clear     = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        check("drain_empty", 32'(sb_q.size()), 32'(0));
    endtask

    initial begin
        reset_n   = 1'b0;
        clear     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        repeat (3) @(negedge clk);
        check_reset_outs();
        reset_n = 1'b1;
        sweep_check("sweep_len_reset");

        // Fresh memory reads zero
        issue(1'b0, 6'h00, '0, 2'b00);
        idle();
        drain();

        // One word per bank (bank 3 is out of range), then back-to-back reads
        issue(1'b1, 6'h00, 16'h0001, 2'b11);
        issue(1'b1, 6'h10, 16'h0002, 2'b11);
        issue(1'b1, 6'h20, 16'h0003, 2'b11);
        issue(1'b1, 6'h30, 16'h0004, 2'b11);
        issue(1'b0, 6'h00, '0, 2'b00);
        issue(1'b0, 6'h10, '0, 2'b00);
        issue(1'b0, 6'h20, '0, 2'b00);
        issue(1'b0, 6'h30, '0, 2'b00);
        issue(1'b1, 6'h20, 16'h0033, 2'b11);
        issue(1'b0, 6'h10, '0, 2'b00);
        idle();
        drain();

        // Byte enables, including an all-disabled no-op write
        issue(1'b1, 6'h05, 16'hBEEF, 2'b11);
        issue(1'b1, 6'h05, 16'h12AA, 2'b01);
        issue(1'b1, 6'h05, 16'h7777, 2'b00);
        issue(1'b0, 6'h05, '0, 2'b00);
        // Out-of-range write must not disturb any bank
        issue(1'b1, 6'h3F, 16'h5555, 2'b11);
        issue(1'b0, 6'h3F, '0, 2'b00);
        issue(1'b0, 6'h20, '0, 2'b00);
        // Read immediately after write of the same address
        issue(1'b1, 6'h13, 16'h00A5, 2'b11);
        issue(1'b0, 6'h13, '0, 2'b00);
        idle();
        drain();

        // Clear with reads in flight: responses still arrive, ready drops
        issue(1'b0, 6'h05, '0, 2'b00);
        issue(1'b0, 6'h13, '0, 2'b00);
        pulse_clear();
        check("ready_drop_on_clear", 32'(req_ready), 32'(0));
        check("busy_on_clear", 32'(busy), 32'(1));
        sweep_check("sweep_len_clear");
        issue(1'b0, 6'h05, '0, 2'b00);
        issue(1'b0, 6'h13, '0, 2'b00);
        issue(1'b0, 6'h00, '0, 2'b00);
        idle();
        drain();

        // Clear during a sweep restarts the counter
        pulse_clear();
        repeat (5) @(negedge clk);
        pulse_clear();
        sweep_check("sweep_len_restart");

        // Reset in the middle of a sweep with a read in flight
        issue(1'b1, 6'h07, 16'hCAFE, 2'b11);
        issue(1'b0, 6'h07, '0, 2'b00);
        pulse_clear();
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_reset_outs();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        sweep_check("sweep_len_midreset");

        // Randomised traffic with occasional clears
        for (int k = 0; k < 400; k++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 2) begin
                pulse_clear();
            end else if (r < 12) begin
                idle();
            end else begin
                issue(1'($urandom_range(0, 1)), 6'($urandom_range(0, SPACE - 1)),
                      16'($urandom), 2'($urandom_range(0, 3)));
            end
        end
        idle();
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/banked_memory_ctrl.md
Name: banked_memory_ctrl

Overview:
Parametrised successor to the single-port storage wrapper. Splits a flat word address into bank-select and in-bank offset over NUM_BANKS single-port synchronous RAM banks (one iCE40 SPRAM each at default size). Adds a valid/ready request port, pipelined reads with fixed latency, byte-enable writes, out-of-range detection, and a hardware zero-clear sweep. Sits between the processor-side datapath and the banked RAM primitives.

Parameters:
DATA_W, 16, word width in bits; must be a multiple of 8
BANK_AW, 14, in-bank offset width; BANK_DEPTH = 2**BANK_AW words per bank
NUM_BANKS, 4, number of banks instantiated, 1..2**(ADDR_W-BANK_AW)
ADDR_W, 16, request address width; bank index = req_addr[ADDR_W-1:BANK_AW]

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
clear  in  1  single-cycle pulse; starts a zero-clear sweep
req_valid  in  1  request present
req_ready  out  1  controller accepts a request this cycle
req_write  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  word address
req_wdata  in  DATA_W  write data
req_be  in  DATA_W/8  byte enables for writes; ignored for reads
rsp_valid  out  1  read response valid, one-cycle pulse per read
rsp_rdata  out  DATA_W  read data
rsp_err  out  1  read hit a nonexistent bank; qualified by rsp_valid
busy  out  1  clear sweep in progress

Behaviour:
- Reset (async assert, sync release): state = CLEAR, clear counter = 0, req_ready = 0, busy = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, read pipeline emptied. RAM contents not reset directly; the sweep zeroes them.
- States: CLEAR, IDLE.
- CLEAR: each cycle writes 0 to offset = counter in every bank in parallel, all bytes enabled; counter increments. Counter reaching BANK_DEPTH-1 -> IDLE on the next edge. Takes exactly BANK_DEPTH cycles. busy = 1, req_ready = 0.
- IDLE: req_ready = 1, busy = 0. The request is accepted on an edge where req_valid & req_ready.
- clear pulse in IDLE -> CLEAR, counter = 0; req_ready drops the cycle after the pulse. Reads already accepted still return responses. clear during CLEAR restarts the counter at 0.
- Accepted write: bytes with req_be[i] = 1 are written on the accepting edge; other bytes keep their old value. No response generated. be = 0 is a legal no-op.
- Accepted read accepted at edge N: RAM read at edge N+1, output register loads at edge N+2. rsp_valid is high for exactly one cycle after edge N+2 (latency 2). Fully pipelined: back-to-back reads give back-to-back responses in request order.
- Write at edge N, then read of the same address at edge N+1: the read returns the new data.
- Out-of-range: bank index >= NUM_BANKS. A write is dropped and all banks are left unchanged. A read returns rsp_rdata = 0, rsp_err = 1 at normal latency. In-range reads give rsp_err = 0.
- Bank select for the read data path is pipelined alongside the request, so responses never take data from a different bank.
- rsp_rdata holds its last value while rsp_valid = 0.
- Mid-operation reset: the pipeline is flushed, no response is emitted for flushed reads, and the sweep restarts.

Test Plan:
- Sweep: release reset with BANK_AW=4, NUM_BANKS=4 -> busy = 1 and req_ready = 0 for exactly 16 cycles, then IDLE. A read of 0x0000 returns 0x0000 with rsp_err = 0, 2 cycles after acceptance.
- Banking at defaults: write 0x0001@0x0000, 0x0002@0x4000, 0x0003@0x8000, 0x0004@0xC000 on consecutive cycles, then 4 back-to-back reads -> rsp_valid on 4 consecutive cycles with data 1,2,3,4. Re-reading 0x4000 still returns 2 after a 0x8000 write, so there is no aliasing.
- Byte enables: write 0xBEEF@0x0010 with be = 11, then 0x12AA with be = 01 -> read returns 0xBEAA.
- Out-of-range: NUM_BANKS = 3, write 0x5555@0xC000 -> read 0xC000 gives rsp_err = 1, rsp_rdata = 0. Read 0x8000 still gives its prior value with rsp_err = 0.
- Read-after-write: write 0x00A5@0x0123 at edge N, read 0x0123 at edge N+1 -> rsp_valid after edge N+3, data 0x00A5.
- Clear and reset: with reads in flight, pulse clear -> in-flight responses still arrive and req_ready drops. After the sweep, every written address reads 0. Assert reset_n low mid-sweep -> outputs go to their reset values immediately, and the sweep restarts from 0 after release.
